// File: rtl/regfile_mp_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  // Widest entry the byte-merge helper handles; callers zero-extend into it.
  localparam int MERGE_W = 256;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  // Byte-enabled merge: bytes with be set come from nv, the rest from old_v.
  function automatic logic [MERGE_W-1:0] merge(
    input logic [MERGE_W-1:0]   old_v,
    input logic [MERGE_W-1:0]   nv,
    input logic [MERGE_W/8-1:0] be
  );
    logic [MERGE_W-1:0] r;
    r = old_v;
    for (int i = 0; i < MERGE_W/8; i++)
      if (be[i]) r[8*i +: 8] = nv[8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Write/read/clear bus of the register file.
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int N_RD   = 2
);
  logic                         en;
  logic                         we;
  logic [ADDR_W-1:0]            waddr;
  logic [DATA_W-1:0]            wdata;
  logic [DATA_W/8-1:0]          wbe;
  logic [N_RD-1:0]              re;
  logic [N_RD-1:0][ADDR_W-1:0]  raddr;
  logic [N_RD-1:0][DATA_W-1:0]  rdata;
  logic [N_RD-1:0]              rvalid;
  logic                         clr_req;
  logic                         clr_busy;

  modport master (
    output en, we, waddr, wdata, wbe, re, raddr, clr_req,
    input  rdata, rvalid, clr_busy
  );

  modport slave (
    input  en, we, waddr, wdata, wbe, re, raddr, clr_req,
    output rdata, rvalid, clr_busy
  );
endinterface

// File: rtl/regfile_mp_clear_seq.sv
// Clear sequencer: walks every entry once, writing zero, after reset or on request.
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req_i,
  output logic              clr_busy_o,
  output logic              clr_we_o,
  output logic [ADDR_W-1:0] clr_addr_o
);
  localparam int DEPTH = 2**ADDR_W;
  // One extra counter bit keeps the last-entry compare unambiguous.
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH-1);

  clr_state_e      state_q, state_d;
  logic [ADDR_W:0] cnt_q, cnt_d;

  // State and counter registers; reset (re)starts a full clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: CLEAR advances one entry per cycle; IDLE waits for a request.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clr_req_i) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign clr_busy_o = (state_q == CLEAR);
  assign clr_we_o   = (state_q == CLEAR);
  assign clr_addr_o = cnt_q[ADDR_W-1:0];

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file: byte-enabled write, registered reads
// with write-to-read bypass, optional hard-wired zero entry, clear engine.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int N_RD     = 2,
  parameter int ZERO_REG = 1
) (
  input  logic         clk,
  input  logic         rst,
  regfile_mp_if.slave  bus
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int NB    = DATA_W/8;

  logic [DATA_W-1:0]           mem [DEPTH];

  logic                        clr_busy;
  logic                        clr_we;
  logic [ADDR_W-1:0]           clr_addr;

  logic                        wr_ok;
  logic [DATA_W-1:0]           wr_merged;
  logic [MERGE_W-1:0]          m_old, m_new, m_out;
  logic [MERGE_W/8-1:0]        m_be;

  logic [N_RD-1:0]             rd_ok;
  logic [N_RD-1:0][DATA_W-1:0] rd_val;
  logic [N_RD-1:0][DATA_W-1:0] rdata_q;
  logic [N_RD-1:0]             rvalid_q;

  regfile_clear_seq #(.ADDR_W(ADDR_W)) u_clr (
    .clk        (clk),
    .rst        (rst),
    .clr_req_i  (bus.clr_req),
    .clr_busy_o (clr_busy),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr)
  );

  // A user write lands only in IDLE, and loses to a same-cycle clear request.
  assign wr_ok = bus.en && bus.we && !clr_busy && !bus.clr_req &&
                 !((ZERO_REG != 0) && (bus.waddr == '0));

  // Merged entry value: feeds both the storage write and the read bypass.
  always_comb begin
    m_old = '0;
    m_new = '0;
    m_be  = '0;
    m_old[DATA_W-1:0] = mem[bus.waddr];
    m_new[DATA_W-1:0] = bus.wdata;
    m_be[NB-1:0]      = bus.wbe;
    m_out = merge(m_old, m_new, m_be);
  end

  assign wr_merged = m_out[DATA_W-1:0];

  if (DATA_W < MERGE_W) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^m_out[MERGE_W-1:DATA_W];
  end

  // Storage: the clear engine owns the write port while it runs.
  always_ff @(posedge clk) begin
    if (clr_we)     mem[clr_addr]  <= '0;
    else if (wr_ok) mem[bus.waddr] <= wr_merged;
  end

  // Per-port read value: zero entry first, then bypass, then storage.
  always_comb begin
    rd_ok  = '0;
    rd_val = '0;
    for (int k = 0; k < N_RD; k++) begin
      rd_ok[k] = bus.en && bus.re[k] && !clr_busy;
      if ((ZERO_REG != 0) && (bus.raddr[k] == '0))
        rd_val[k] = '0;
      else if (wr_ok && (bus.raddr[k] == bus.waddr))
        rd_val[k] = wr_merged;
      else
        rd_val[k] = mem[bus.raddr[k]];
    end
  end

  // Read capture registers; data holds when a port is not read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q  <= '0;
      rvalid_q <= '0;
    end else begin
      for (int k = 0; k < N_RD; k++) begin
        rvalid_q[k] <= rd_ok[k];
        if (rd_ok[k]) rdata_q[k] <= rd_val[k];
      end
    end
  end

  assign bus.rdata    = rdata_q;
  assign bus.rvalid   = rvalid_q;
  assign bus.clr_busy = clr_busy;

endmodule
